alu_dispatch: RTL
=================

Name: alu_dispatch

Overview:
Request buffer and issue stage that sits directly upstream of alu_bool.
- Accepts operand/opcode requests over a valid/ready handshake and queues them in a small FIFO.
- Issues the head entry to the combinational alu_bool through the A/B/opcode/en connection.
- Registers the returned result, with its tag, into an output stage that has its own valid/ready handshake.
- Gives the pure-combinational ALU a flow-controlled, in-order, one-result-per-cycle pipeline wrapper.

Parameters:
WIDTH, 32, operand/result width; must match the connected alu_bool.
DEPTH, 4, FIFO entries; power of two, >= 2.
TAG_W, 4, width of the request tag carried alongside each operation.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  request present.
in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
in_A  input  WIDTH  operand A.
in_B  input  WIDTH  operand B.
in_opcode  input  4  ALU opcode.
in_tag  input  TAG_W  caller tag, returned with the result.
alu_A  output  WIDTH  to alu_bool A.
alu_B  output  WIDTH  to alu_bool B.
alu_opcode  output  4  to alu_bool opcode.
alu_en  output  1  to alu_bool en.
alu_result  input  WIDTH  from alu_bool result.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result.
out_result  output  WIDTH  registered result.
out_tag  output  TAG_W  tag of that result.
count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset:
- rst is asynchronous and active-high. While asserted:
  - wr_ptr, rd_ptr and count are 0.
  - out_valid, out_result and out_tag are 0.
  - in_ready is 0.
- All queued entries and the output-register contents are discarded.
- in_ready rises in the first cycle after rst deasserts.

Push and FIFO pointers:
- in_ready = !rst && (count < DEPTH). It depends only on registered count, never on a same-cycle pop, so a full FIFO refuses a push even in a cycle that pops.
- A push writes {in_A, in_B, in_opcode, in_tag} at wr_ptr. Pointers wrap modulo DEPTH.

Issue condition:
- issue = (count != 0) && (!out_valid || out_ready).

ALU drive:
- When issue = 1:
  - alu_en = 1.
  - alu_A, alu_B and alu_opcode are driven from the head entry.
- When issue = 0:
  - alu_en = 0.
  - alu_A, alu_B and alu_opcode are driven to 0.

Output register:
- On an edge with issue = 1:
  - out_result <= alu_result, out_tag <= head tag, out_valid <= 1.
  - The head is popped (rd_ptr advances).
- On an edge with out_valid && out_ready && !issue: out_valid <= 0. out_result and out_tag hold their values.
- While out_valid && !out_ready, out_result and out_tag remain stable.

Occupancy:
- count +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.

Latency and throughput:
- A request accepted at edge k appears with out_valid at edge k+1 at the earliest (no bypass).
- Sustained throughput is 1 result per cycle when out_ready is held high.

Ordering and opcodes:
- Results are returned strictly in request order.
- Opcodes are not checked. An opcode that alu_bool does not decode returns 0 and is still delivered with out_valid.

Reset mid-operation:
- Any in-flight result is dropped and nothing is replayed.

Optional Feature:
Macro: ALU_DISPATCH_BYPASS_EN.
Defined:
- When count == 0, in_valid && in_ready, and (!out_valid || out_ready), the incoming request bypasses the FIFO.
- It drives the ALU the same cycle: alu_en = 1, with alu_A/alu_B/alu_opcode taken from the in_* ports.
- The result is loaded into the output register at that edge, so out_valid is asserted after the accept edge itself.
- count does not change for a bypassed request.
Undefined:
- Every request passes through the FIFO, and the minimum latency is as stated in Behaviour.

Decomposition:
Package alu_pkg:
- typedef logic [3:0] opcode_t.
- Opcode constants OPCODE_XOR = 4'b0100 and OPCODE_NOR = 4'b0101.
- These are shared with the ALU and the bench.
The request struct is WIDTH-dependent, so it stays local to the module.
Sub-module alu_dispatch_fifo (WIDTH, DEPTH, payload-width parameterised):
- Holds the storage, pointers and count.
- alu_dispatch adds the issue logic, ALU drive and output register.

Test Plan:
1. Assert rst mid-stream with count = 3 and out_valid = 1 -> in the same cycle out_valid = 0, count = 0, in_ready = 0. After release, in_ready = 1 and no stale results appear.
2. Single XOR, A = 0xFFFF0000, B = 0x0F0F0F0F, opcode 4'b0100, tag 3, out_ready = 1 -> out_result = 0xF0F00F0F, out_tag = 3, out_valid high for exactly one cycle at edge k+1.
3. Hold out_ready = 0 and push tags 0–5 -> tag 0 sits in the output register, tags 1–4 fill the FIFO, count = 4, in_ready = 0, tag 5 is held at the input. Release out_ready -> tags 0,1,2,3,4,5 emerge in order, one per cycle.
4. NOR with A = 0x0000FFFF, B = 0x00FF00FF -> 0xFF000000. Opcode 4'b1111 -> out_result = 0, out_valid = 1.
5. At count = 2, push and pop in the same cycle -> count stays 2 and ordering is preserved.
6. With ALU_DISPATCH_BYPASS_EN, empty FIFO, push at edge k -> out_valid at edge k, count stays 0. Without the macro -> out_valid at edge k+1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode type and constants shared by alu_bool, alu_dispatch and the bench
package alu_pkg;
    typedef logic [3:0] opcode_t;
    localparam opcode_t OPCODE_XOR = 4'b0100;
    localparam opcode_t OPCODE_NOR = 4'b0101;
endpackage

// File: rtl/alu_dispatch_fifo.sv
// alu_dispatch_fifo: circular request buffer with write/read pointers and occupancy count
module alu_dispatch_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4,
    parameter int PW    = 2 * WIDTH + $bits(opcode_t) + TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [PW-1:0]          wdata,
    output logic [PW-1:0]          rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // payload storage; pointers alone decide which entries are live, so no reset
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
        end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: in-order request FIFO, alu_bool issue stage and registered result handshake (optional ALU_DISPATCH_BYPASS_EN)
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_A,
    input  logic [WIDTH-1:0]       in_B,
    input  logic [3:0]             in_opcode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [WIDTH-1:0]       alu_A,
    output logic [WIDTH-1:0]       alu_B,
    output logic [3:0]             alu_opcode,
    output logic                   alu_en,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        opcode_t          opcode;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t wr_req, head;
    logic push, issue, bypass, fire, room;

    assign wr_req = '{a: in_A, b: in_B, opcode: in_opcode, tag: in_tag};
    assign in_ready = !rst && (count < CW'(DEPTH));
    assign room = !out_valid || out_ready;
    assign issue = (count != '0) && room;
`ifdef ALU_DISPATCH_BYPASS_EN
    assign bypass = (count == '0) && in_valid && in_ready && room;
`else
    assign bypass = 1'b0;
`endif
    assign push = in_valid && in_ready && !bypass;
    assign fire = issue || bypass;

    alu_dispatch_fifo #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (issue),
        .wdata(wr_req),
        .rdata(head),
        .count(count)
    );

    // ALU sees the bypassed request, else the FIFO head, else idles at zero
    always_comb begin
        alu_en     = fire;
        alu_A      = bypass ? in_A : issue ? head.a : '0;
        alu_B      = bypass ? in_B : issue ? head.b : '0;
        alu_opcode = bypass ? in_opcode : issue ? head.opcode : '0;
    end

    // result register: load on issue, otherwise drop valid once consumed
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (fire) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_tag    <= bypass ? in_tag : head.tag;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
endmodule
